// File: rtl/accel_sample_sequencer.sv
`default_nettype none
//============================================================================
// Module   : accel_sample_sequencer
// Brief    : Periodically reads the X, Y and Z accelerometer axes through one
//            shared read port and publishes each coherent triple to the Nios
//            PIO inputs behind a valid/ack handshake, with a sticky overrun
//            flag and a wrapping published-sample counter.
// Options  : define ACCEL_AVG4_EN to publish a 4-sample moving average per
//            axis (adds one pipeline cycle before publication).
// Revision : 1.0 - initial release
//============================================================================
module accel_sample_sequencer #(
  parameter int DATA_W      = 16,
  parameter int DIV_W       = 20,
  parameter int DEFAULT_DIV = 50000
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              enable,
  input  logic              div_load,
  input  logic [DIV_W-1:0]  div_value,
  output logic              rd_req,
  output logic [1:0]        rd_axis,
  input  logic              rd_ack,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] accel_x,
  output logic [DATA_W-1:0] accel_y,
  output logic [DATA_W-1:0] accel_z,
  output logic              sample_valid,
  input  logic              sample_ack,
  output logic              overrun,
  input  logic              overrun_clr,
  output logic [15:0]       sample_count
);

  localparam logic [DIV_W-1:0] C_ONE         = DIV_W'(1);
  localparam logic [DIV_W-1:0] C_DEFAULT_DIV = DIV_W'(DEFAULT_DIV);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ_X   = 3'd1,
    S_REQ_Y   = 3'd2,
    S_REQ_Z   = 3'd3,
    S_PUBLISH = 3'd4
  } state_t;

  state_t                   state_q, state_d;
  logic [DIV_W-1:0]         div_reg_q, div_reg_d;
  logic [DIV_W-1:0]         cnt_q, cnt_d;
  logic [DIV_W-1:0]         w_load_val;
  logic                     w_tick;
  logic                     w_pub;
  logic                     w_ovr_set;
  logic [2:0]               w_cap;
  logic [2:0][DATA_W-1:0]   w_pub_data;
  logic [2:0][DATA_W-1:0]   accel_q;
  logic                     sample_valid_q, sample_valid_d;
  logic                     overrun_q, overrun_d;
  logic [15:0]              sample_count_q;

  // A zero period would never tick; treat it as one clock per tick.
  assign w_load_val = (div_value == '0) ? C_ONE : div_value;
  assign w_tick     = enable && (cnt_q == '0);

  // Divider next state: load wins, disable parks the counter at reload.
  always_comb begin
    div_reg_d = div_reg_q;
    cnt_d     = cnt_q;
    if (div_load) begin
      div_reg_d = w_load_val;
      cnt_d     = w_load_val - C_ONE;
    end else if (!enable || (cnt_q == '0)) begin
      cnt_d = div_reg_q - C_ONE;
    end else begin
      cnt_d = cnt_q - C_ONE;
    end
  end

  // Divider registers.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      div_reg_q <= C_DEFAULT_DIV;
      cnt_q     <= C_DEFAULT_DIV - C_ONE;
    end else begin
      div_reg_q <= div_reg_d;
      cnt_q     <= cnt_d;
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Sequencer next state and read-port outputs; each axis waits for rd_ack.
  always_comb begin
    state_d = state_q;
    rd_req  = 1'b0;
    rd_axis = 2'd0;
    case (state_q)
      S_IDLE: begin
        if (w_tick) state_d = S_REQ_X;
      end
      S_REQ_X: begin
        rd_req  = 1'b1;
        rd_axis = 2'd0;
        if (rd_ack) state_d = S_REQ_Y;
      end
      S_REQ_Y: begin
        rd_req  = 1'b1;
        rd_axis = 2'd1;
        if (rd_ack) state_d = S_REQ_Z;
      end
      S_REQ_Z: begin
        rd_req  = 1'b1;
        rd_axis = 2'd2;
        if (rd_ack) state_d = S_PUBLISH;
      end
      S_PUBLISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Per-axis capture strobes; rd_ack outside a request state is ignored.
  assign w_cap = {(state_q == S_REQ_Z) && rd_ack,
                  (state_q == S_REQ_Y) && rd_ack,
                  (state_q == S_REQ_X) && rd_ack};

`ifdef ACCEL_AVG4_EN
  logic pipe_q;

  // Sum of four signed samples in DATA_W+2 bits, then arithmetic shift by 2.
  function automatic logic [DATA_W-1:0] avg4(input logic [3:0][DATA_W-1:0] h);
    logic [DATA_W+1:0] sum;
    sum = '0;
    for (int k = 0; k < 4; k++) begin
      sum = sum + {{2{h[k][DATA_W-1]}}, h[k]};
    end
    return sum[DATA_W+1:2];
  endfunction

  // Averages are registered in PUBLISH and released one cycle later.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      pipe_q <= 1'b0;
    end else begin
      pipe_q <= (state_q == S_PUBLISH);
    end
  end

  assign w_pub = pipe_q;

  for (genvar a = 0; a < 3; a++) begin : g_axis
    logic [3:0][DATA_W-1:0] hist_q;
    logic [DATA_W-1:0]      avg_q;

    // History shifts on every capture; average is taken in PUBLISH.
    always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
        hist_q <= '0;
        avg_q  <= '0;
      end else begin
        if (w_cap[a]) hist_q <= {hist_q[2:0], rd_data};
        if (state_q == S_PUBLISH) avg_q <= avg4(hist_q);
      end
    end

    assign w_pub_data[a] = avg_q;
  end
`else
  assign w_pub = (state_q == S_PUBLISH);

  for (genvar a = 0; a < 3; a++) begin : g_axis
    logic [DATA_W-1:0] shadow_q;

    // Shadow holds this sequence's raw sample until PUBLISH.
    always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
        shadow_q <= '0;
      end else if (w_cap[a]) begin
        shadow_q <= rd_data;
      end
    end

    assign w_pub_data[a] = shadow_q;
  end
`endif

  // Handshake and overrun next state; a set condition beats overrun_clr.
  always_comb begin
    w_ovr_set = (w_pub && sample_valid_q && !sample_ack) ||
                (w_tick && (state_q != S_IDLE));
    sample_valid_d = sample_valid_q;
    if (w_pub) begin
      sample_valid_d = 1'b1;
    end else if (sample_ack) begin
      sample_valid_d = 1'b0;
    end
    overrun_d = overrun_q;
    if (w_ovr_set) begin
      overrun_d = 1'b1;
    end else if (overrun_clr) begin
      overrun_d = 1'b0;
    end
  end

  // Published snapshot, flags and counter.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      accel_q        <= '0;
      sample_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
      sample_count_q <= '0;
    end else begin
      sample_valid_q <= sample_valid_d;
      overrun_q      <= overrun_d;
      if (w_pub) begin
        accel_q        <= w_pub_data;
        sample_count_q <= sample_count_q + 16'd1;
      end
    end
  end

  assign accel_x      = accel_q[0];
  assign accel_y      = accel_q[1];
  assign accel_z      = accel_q[2];
  assign sample_valid = sample_valid_q;
  assign overrun      = overrun_q;
  assign sample_count = sample_count_q;

endmodule
`default_nettype wire

// File: tb/tb_accel_sample_sequencer.sv
`default_nettype none
//============================================================================
// Module   : tb_accel_sample_sequencer
// Brief    : Scoreboard bench for accel_sample_sequencer. A responder model
//            answers reads and predicts each publish (data, count, cycle);
//            a monitor compares whenever sample_count advances.
// Options  : build with ACCEL_AVG4_EN to match an averaging DUT.
// Revision : 1.0 - initial release
//============================================================================
module tb_accel_sample_sequencer;

  localparam int DATA_W      = 16;
  localparam int DIV_W       = 20;
  localparam int DEFAULT_DIV = 20;
`ifdef ACCEL_AVG4_EN
  localparam int AVG_LAT = 1;
  localparam logic [15:0] AVG_LAST_X = 16'd10;
`else
  localparam int AVG_LAT = 0;
  localparam logic [15:0] AVG_LAST_X = 16'd16;
`endif

  logic              clk_clk = 1'b0;
  logic              reset_reset = 1'b1;
  logic              enable = 1'b0;
  logic              div_load = 1'b0;
  logic [DIV_W-1:0]  div_value = '0;
  logic              rd_req;
  logic [1:0]        rd_axis;
  logic              rd_ack;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] accel_x, accel_y, accel_z;
  logic              sample_valid;
  logic              sample_ack;
  logic              overrun;
  logic              overrun_clr = 1'b0;
  logic [15:0]       sample_count;

  always #5 clk_clk = ~clk_clk;

  accel_sample_sequencer #(
    .DATA_W(DATA_W), .DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV)
  ) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .enable(enable),
    .div_load(div_load), .div_value(div_value), .rd_req(rd_req),
    .rd_axis(rd_axis), .rd_ack(rd_ack), .rd_data(rd_data),
    .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z),
    .sample_valid(sample_valid), .sample_ack(sample_ack),
    .overrun(overrun), .overrun_clr(overrun_clr), .sample_count(sample_count)
  );

  typedef struct {
    logic [15:0] x, y, z, cnt;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] fx[$], fy[$], fz[$];
  int          checks = 0, errors = 0;
  int          cyc = 0, pubs = 0;

  // Bench-side controls (written only by the main process).
  int wait_mode = 0;      // <0: random 0..3 wait cycles per axis
  int auto_mode = 0;      // 0: directed acks, 1: random acks, 2: always ack
  int ack_req_n = 0;
  bit ack_noise = 0;
  bit check_period = 0;
  int period_exp = 0;
  int period_epoch = 0;
  int first_epoch = 0;

  // Reference model state (written only by the responder).
  logic [15:0] shadow[3];
  logic [15:0] hist[3][4];

  always @(posedge clk_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [15:0] model_avg(input int a);
    int s = 0;
    for (int k = 0; k < 4; k++) s += $signed(hist[a][k]);
    return 16'(s >>> 2);
  endfunction

  // Read-port responder and reference model: predicts every publish.
  initial begin : p_resp
    exp_t        e;
    int          axis_idx = 0, cur_wait = 0, wcnt = 0, waits_tot = 0;
    int          start_c = 0, prev_start = -1, last_rst = 0;
    int          seen_pe = 0, seen_fe = 0;
    bit          in_seq = 0, new_axis = 1, want_first = 0;
    logic [15:0] exp_cnt = 0;
    rd_ack  = 1'b0;
    rd_data = '0;
    forever begin
      @(posedge clk_clk); #1;
      if (period_epoch != seen_pe) begin seen_pe = period_epoch; prev_start = -1; end
      if (first_epoch != seen_fe) begin seen_fe = first_epoch; want_first = 1; end
      rd_ack  = 1'b0;
      rd_data = 16'($urandom);
      if (reset_reset) begin
        axis_idx = 0; in_seq = 0; new_axis = 1; exp_cnt = 0;
        prev_start = -1; last_rst = cyc;
        exp_q.delete();
        for (int a = 0; a < 3; a++)
          for (int k = 0; k < 4; k++) hist[a][k] = '0;
      end else if (rd_req) begin
        if (!in_seq) begin
          in_seq = 1; start_c = cyc; waits_tot = 0;
          if (want_first) begin
            want_first = 0;
            check("first_start_after_reset", 32'(cyc - last_rst), 32'(DEFAULT_DIV));
          end
          if (check_period && prev_start >= 0)
            check("tick_period", 32'(cyc - prev_start), 32'(period_exp));
          prev_start = cyc;
        end
        check("rd_axis", 32'(rd_axis), 32'(axis_idx));
        if (new_axis) begin
          cur_wait = (wait_mode < 0) ? int'($urandom_range(0, 3)) : wait_mode;
          wcnt = 0; new_axis = 0;
        end
        if (wcnt == cur_wait) begin
          rd_ack = 1'b1;
          if (axis_idx == 0 && fx.size() > 0) rd_data = fx.pop_front();
          if (axis_idx == 1 && fy.size() > 0) rd_data = fy.pop_front();
          if (axis_idx == 2 && fz.size() > 0) rd_data = fz.pop_front();
          shadow[axis_idx] = rd_data;
          for (int k = 3; k > 0; k--) hist[axis_idx][k] = hist[axis_idx][k-1];
          hist[axis_idx][0] = rd_data;
          waits_tot += cur_wait;
          new_axis = 1;
          axis_idx++;
          if (axis_idx == 3) begin
            exp_cnt = exp_cnt + 16'd1;
`ifdef ACCEL_AVG4_EN
            e.x = model_avg(0); e.y = model_avg(1); e.z = model_avg(2);
`else
            e.x = shadow[0]; e.y = shadow[1]; e.z = shadow[2];
`endif
            e.cnt = exp_cnt;
            e.cyc = start_c + 4 + waits_tot + AVG_LAT;
            exp_q.push_back(e);
            axis_idx = 0; in_seq = 0;
          end
        end else begin
          wcnt++;
        end
      end else if (ack_noise && $urandom_range(0, 3) == 0) begin
        rd_ack = 1'b1;
      end
    end
  end

  // Nios side: consumes snapshots according to auto_mode.
  initial begin : p_nios
    int served = 0;
    sample_ack = 1'b0;
    forever begin
      @(posedge clk_clk); #1;
      if (auto_mode == 1)      sample_ack = sample_valid && ($urandom_range(0, 2) == 0);
      else if (auto_mode == 2) sample_ack = sample_valid;
      else if (served < ack_req_n) begin sample_ack = 1'b1; served++; end
      else                     sample_ack = 1'b0;
    end
  end

  // Monitor: every advance of sample_count is one publish to compare.
  initial begin : p_mon
    exp_t        e;
    logic [15:0] prev = 0;
    forever begin
      @(posedge clk_clk); #1;
      if (reset_reset) begin
        prev = 0;
      end else if (sample_count !== prev) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_publish: actual count 0x%0h required no publish", sample_count);
        end else begin
          e = exp_q.pop_front();
          check("pub_x", 32'(accel_x), 32'(e.x));
          check("pub_y", 32'(accel_y), 32'(e.y));
          check("pub_z", 32'(accel_z), 32'(e.z));
          check("pub_count", 32'(sample_count), 32'(e.cnt));
          check("pub_cycle", 32'(cyc), 32'(e.cyc));
          check("pub_valid", 32'(sample_valid), 32'd1);
        end
        prev = sample_count;
        pubs++;
      end
    end
  end

  task automatic load_div(input int v);
    @(negedge clk_clk); div_value = DIV_W'(v); div_load = 1'b1;
    @(negedge clk_clk); div_load = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk_clk); overrun_clr = 1'b1;
    @(negedge clk_clk); overrun_clr = 1'b0;
  endtask

  task automatic wait_pubs(input int n, input int budget);
    int target = pubs + n;
    int k = 0;
    while (pubs < target && k < budget) begin @(negedge clk_clk); k++; end
    if (pubs < target) begin
      checks++; errors++;
      $display("FAIL wait_publish: actual %0d publishes required %0d", pubs, target);
    end
  endtask

  task automatic check_reset_state();
    check("rst_rd_req", 32'(rd_req), 32'd0);
    check("rst_rd_axis", 32'(rd_axis), 32'd0);
    check("rst_accel_x", 32'(accel_x), 32'd0);
    check("rst_accel_y", 32'(accel_y), 32'd0);
    check("rst_accel_z", 32'(accel_z), 32'd0);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_count", 32'(sample_count), 32'd0);
  endtask

  initial begin : p_main
    int k;
    // Reset state.
    repeat (3) @(negedge clk_clk);
    check_reset_state();
    reset_reset = 1'b0;

    // Zero-wait responder, period 8, fixed first triple.
    fx.push_back(16'h0123); fy.push_back(16'hFF00); fz.push_back(16'h7FFF);
    wait_mode = 0; period_exp = 8; period_epoch++; check_period = 1;
    load_div(8);
    enable = 1'b1;
    wait_pubs(1, 100);
    check("t1_count", 32'(sample_count), 32'd1);
`ifndef ACCEL_AVG4_EN
    check("t1_x", 32'(accel_x), 32'h0123);
    check("t1_y", 32'(accel_y), 32'hFF00);
    check("t1_z", 32'(accel_z), 32'h7FFF);
`endif
    auto_mode = 2;
    wait_pubs(3, 100);
    check_period = 0;

    // Three wait cycles per axis; long period so nothing overruns.
    wait_mode = 3;
    load_div(20);
    wait_pubs(1, 200);
    pulse_clr();
    wait_pubs(2, 200);
    check("t2_no_overrun", 32'(overrun), 32'd0);

    // Unconsumed snapshot overwritten -> overrun; then cleared.
    auto_mode = 0; wait_mode = 0;
    load_div(8);
    wait_pubs(1, 200);
    ack_req_n++;
    pulse_clr();
    wait_pubs(1, 100);
    check("t3_first_no_overrun", 32'(overrun), 32'd0);
    wait_pubs(1, 100);
    check("t3_overrun_set", 32'(overrun), 32'd1);
    check("t3_valid_held", 32'(sample_valid), 32'd1);
    pulse_clr();
    check("t3_overrun_clr", 32'(overrun), 32'd0);

    // Tick every cycle with slow responder: dropped ticks set overrun.
    auto_mode = 2; wait_mode = 2;
    load_div(1);
    pulse_clr();
    wait_pubs(2, 100);
    check("t4_overrun_drop", 32'(overrun), 32'd1);
    enable = 1'b0;
    k = 0;
    while (exp_q.size() > 0 && k < 100) begin @(negedge clk_clk); k++; end
    check("t4_drain", 32'(exp_q.size()), 32'd0);
    k = pubs;
    repeat (30) @(negedge clk_clk);
    check("t4_disabled_quiet", 32'(pubs - k), 32'd0);

    // Reset while the Y read is pending.
    auto_mode = 0; wait_mode = 1;
    load_div(8);
    enable = 1'b1;
    wait_pubs(1, 100);
    k = 0;
    while (!(rd_req && rd_axis == 2'd1) && k < 100) begin @(negedge clk_clk); k++; end
    check("t5_reached_req_y", 32'(rd_req && rd_axis == 2'd1), 32'd1);
    first_epoch++;
    reset_reset = 1'b1;
    @(negedge clk_clk);
    check("t5_rd_req", 32'(rd_req), 32'd0);
    check("t5_valid", 32'(sample_valid), 32'd0);
    check("t5_count", 32'(sample_count), 32'd0);
    reset_reset = 1'b0;
    wait_pubs(1, 100);

    // Averaging sequence on X (raw values when averaging is not built in).
    reset_reset = 1'b1;
    enable = 1'b0;
    @(negedge clk_clk);
    check_reset_state();
    reset_reset = 1'b0;
    fx.push_back(16'd4); fx.push_back(16'd8); fx.push_back(16'd12); fx.push_back(16'd16);
    auto_mode = 2; wait_mode = 0;
    load_div(8);
    enable = 1'b1;
    wait_pubs(4, 200);
    check("t6_last_x", 32'(accel_x), 32'(AVG_LAST_X));

    // Randomized traffic against the scoreboard.
    auto_mode = 1; wait_mode = -1; ack_noise = 1;
    repeat (30) begin
      load_div(int'($urandom_range(1, 12)));
      enable = ($urandom_range(0, 4) != 0);
      repeat ($urandom_range(20, 60)) @(negedge clk_clk);
      if ($urandom_range(0, 2) == 0) pulse_clr();
    end

    // Drain outstanding predictions.
    enable = 1'b0; ack_noise = 0;
    k = 0;
    while (exp_q.size() > 0 && k < 200) begin @(negedge clk_clk); k++; end
    check("final_drain", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
